// File: rtl/game_state_ctrl_if.sv
// Control/status bundle between the game sequencer and the input, collision and draw logic.
// The sequencer uses the slave view; whoever drives the inputs uses the master view.
interface game_state_ctrl_if;
    logic       frame_tick;
    logic       btn;
    logic       collision;
    logic       game_run;
    logic       bird_reset;
    logic       score_clr;
    logic       overlay_en;
    logic [1:0] state;

    modport master (
        output frame_tick, btn, collision,
        input  game_run, bird_reset, score_clr, overlay_en, state
    );

    modport slave (
        input  frame_tick, btn, collision,
        output game_run, bird_reset, score_clr, overlay_en, state
    );
endinterface

// File: rtl/game_state_ctrl.sv
// Game sequencer: IDLE/PLAY/DYING/OVER state machine driven by frame ticks, the button and
// collisions. It freezes play, blinks the game-over overlay and pulses bird reset and score clear.
module game_state_ctrl #(
    parameter int unsigned DEATH_FRAMES = 60,
    parameter int unsigned FLASH_FRAMES = 30,
    parameter int unsigned RESTART_LOCK = 30
) (
    input logic             clk,
    input logic             rst,
    game_state_ctrl_if.slave bus
);

    localparam int unsigned FW = $clog2(DEATH_FRAMES + 1);
    localparam int unsigned BW = $clog2(FLASH_FRAMES + 1);
    localparam int unsigned LW = $clog2(RESTART_LOCK + 1);

    localparam logic [FW-1:0] FrameLast = FW'(DEATH_FRAMES - 1);
    localparam logic [FW-1:0] FrameOne  = FW'(1);
    localparam logic [BW-1:0] BlinkLast = BW'(FLASH_FRAMES - 1);
    localparam logic [BW-1:0] BlinkOne  = BW'(1);
    localparam logic [LW-1:0] LockMax   = LW'(RESTART_LOCK);
    localparam logic [LW-1:0] LockOne   = LW'(1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StPlay  = 2'd1,
        StDying = 2'd2,
        StOver  = 2'd3
    } state_e;

    state_e        state_q, state_d;
    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic [LW-1:0] lock_cnt_q, lock_cnt_d;
    logic          btn_q;
    logic          game_run_q, game_run_d;
    logic          bird_reset_q, bird_reset_d;
    logic          score_clr_q, score_clr_d;
    logic          overlay_en_q, overlay_en_d;
    logic          btn_rise;

    // btn_q resets high so a button held through reset must be released before it counts.
    assign btn_rise = bus.btn & ~btn_q;

    always_comb begin
        state_d      = state_q;
        frame_cnt_d  = frame_cnt_q;
        blink_cnt_d  = blink_cnt_q;
        lock_cnt_d   = lock_cnt_q;
        overlay_en_d = overlay_en_q;
        score_clr_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (btn_rise) begin
                    state_d     = StPlay;
                    score_clr_d = 1'b1;
                end
            end
            StPlay: begin
                if (bus.collision) begin
                    state_d     = StDying;
                    frame_cnt_d = '0;
                end
            end
            StDying: begin
                if (bus.frame_tick) begin
                    if (frame_cnt_q == FrameLast) begin
                        state_d      = StOver;
                        overlay_en_d = 1'b1;
                        frame_cnt_d  = '0;
                        blink_cnt_d  = '0;
                        lock_cnt_d   = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + FrameOne;
                    end
                end
            end
            StOver: begin
                // An accepted restart pre-empts any tick in the same cycle.
                if (btn_rise && (lock_cnt_q == LockMax)) begin
                    state_d      = StIdle;
                    overlay_en_d = 1'b0;
                    frame_cnt_d  = '0;
                    blink_cnt_d  = '0;
                    lock_cnt_d   = '0;
                end else if (bus.frame_tick) begin
                    if (blink_cnt_q == BlinkLast) begin
                        overlay_en_d = ~overlay_en_q;
                        blink_cnt_d  = '0;
                    end else begin
                        blink_cnt_d = blink_cnt_q + BlinkOne;
                    end
                    if (lock_cnt_q != LockMax) begin
                        lock_cnt_d = lock_cnt_q + LockOne;
                    end
                end
            end
        endcase

        game_run_d   = (state_d == StPlay);
        bird_reset_d = (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            frame_cnt_q  <= '0;
            blink_cnt_q  <= '0;
            lock_cnt_q   <= '0;
            btn_q        <= 1'b1;
            game_run_q   <= 1'b0;
            bird_reset_q <= 1'b1;
            score_clr_q  <= 1'b0;
            overlay_en_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_cnt_q  <= frame_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            btn_q        <= bus.btn;
            game_run_q   <= game_run_d;
            bird_reset_q <= bird_reset_d;
            score_clr_q  <= score_clr_d;
            overlay_en_q <= overlay_en_d;
        end
    end

    assign bus.state      = state_q;
    assign bus.game_run   = game_run_q;
    assign bus.bird_reset = bird_reset_q;
    assign bus.score_clr  = score_clr_q;
    assign bus.overlay_en = overlay_en_q;

endmodule
